// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit side of the UART. Takes one byte from a valid/ready producer and
// shifts it out on txd as start bit, 8 data bits LSB first, an optional
// parity bit and STOP_BITS stop bits. The bit rate comes from div_clk, which
// is the baud divider output sampled on CLK; it is never used as a clock.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// data bit 7 (even parity for PARITY_ODD = 0, odd for PARITY_ODD = 1).
// Without the macro the parity state, parity logic and register are absent.
module uart_tx_serializer #(
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       CLK,
    input  logic       HRESET,
    input  logic       div_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);

    // An out-of-range configuration degrades to a plain single-stop frame
    // rather than producing an undefined stop count.
    localparam bit CFG_OK = ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                            ((PARITY_ODD == 0) || (PARITY_ODD == 1));

    // Value of the stop counter on the tick that ends the last stop bit.
    localparam logic STOP_LAST = (CFG_OK && (STOP_BITS == 2)) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam logic ODD_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`endif

    // ARM waits for the first usable tick after acceptance; every other
    // state names the bit currently being driven on the line.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] shift_reg;
    logic [7:0] shift_n;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    logic       stop_cnt;
    logic       stop_cnt_n;
    logic       div_clk_q;
    logic       tick;
    logic       txd_n;
    logic       tx_ready_n;
    logic       tx_busy_n;
`ifdef UART_TX_PARITY_EN
    logic       parity_bit;
    logic       parity_n;
`endif

    // One CLK-wide pulse per rising edge of the divided clock marks each bit
    // boundary; div_clk is already in the CLK domain so no synchronizer.
    assign tick = div_clk & ~div_clk_q;

    // State, datapath and registered outputs; reset returns the line to idle
    // at once and abandons any frame in flight.
    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state      <= IDLE;
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            div_clk_q  <= 1'b0;
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            div_clk_q  <= div_clk;
            txd        <= txd_n;
            tx_ready   <= tx_ready_n;
            tx_busy    <= tx_busy_n;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_n;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a tick
    // arrives, so a stalled div_clk freezes the frame in place.
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        txd_n      = txd;
        tx_ready_n = tx_ready;
        tx_busy_n  = tx_busy;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shift_n    = tx_data;
                    tx_ready_n = 1'b0;
                    tx_busy_n  = 1'b1;
                    state_n    = ARM;
`ifdef UART_TX_PARITY_EN
                    parity_n   = (^tx_data) ^ ODD_SENSE;
`endif
                end
            end

            ARM: begin
                if (tick) begin
                    txd_n   = 1'b0;
                    state_n = START;
                end
            end

            START: begin
                if (tick) begin
                    txd_n     = shift_reg[0];
                    shift_n   = {1'b0, shift_reg[7:1]};
                    bit_cnt_n = 3'd0;
                    state_n   = DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_n      = parity_bit;
                        state_n    = PARITY;
`else
                        txd_n      = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = STOP;
`endif
                    end else begin
                        txd_n     = shift_reg[0];
                        shift_n   = {1'b0, shift_reg[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    txd_n      = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = STOP;
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        tx_ready_n = 1'b1;
                        tx_busy_n  = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end

            default: begin
                txd_n      = 1'b1;
                tx_ready_n = 1'b1;
                tx_busy_n  = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Directed bench for uart_tx_serializer. Two instances share CLK, HRESET,
// div_clk and tx_data: dut1 uses 1 stop bit / even parity sense, dut2 uses
// 2 stop bits / odd parity sense. div_clk has an 8-cycle period (D = 3).
// Parity checks are compiled only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

    localparam int BIT_CYC = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic       CLK       = 1'b0;
    logic       HRESET    = 1'b1;
    logic       div_clk   = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready1, tx_busy1, txd1;
    logic       tx_ready2, tx_busy2, txd2;

    logic       sel     = 1'b0;
    logic       div_run = 1'b0;
    int         div_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic       rec_txd  [0:255];
    logic       rec_rdy  [0:255];
    logic       rec_busy [0:255];

    logic       txd_sel, ready_sel, busy_sel;
    assign txd_sel   = sel ? txd2     : txd1;
    assign ready_sel = sel ? tx_ready2 : tx_ready1;
    assign busy_sel  = sel ? tx_busy2  : tx_busy1;

    uart_tx_serializer #(.STOP_BITS(1), .PARITY_ODD(0)) dut1 (
        .CLK(CLK), .HRESET(HRESET), .div_clk(div_clk), .tx_data(tx_data),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_busy(tx_busy1), .txd(txd1)
    );

    uart_tx_serializer #(.STOP_BITS(2), .PARITY_ODD(1)) dut2 (
        .CLK(CLK), .HRESET(HRESET), .div_clk(div_clk), .tx_data(tx_data),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_busy(tx_busy2), .txd(txd2)
    );

    // System clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Baud divider model with D = 3: div_clk toggles every 4 CLK cycles while
    // div_run is set; clearing div_run freezes both the level and the phase.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (div_run) begin
                div_cnt++;
                if (div_cnt == 4) begin
                    div_cnt = 0;
                    div_clk = ~div_clk;
                end
            end
        end
    end

    // Safety net in case a bounded wait is itself miscounted.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line level for bit slot k of a frame: start, 8 data bits LSB
    // first, optional parity, then high for stop bits and idle.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if ((NPAR == 1) && (k == 9)) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // Offer a byte to the selected instance and hold tx_valid until the
    // edge on which tx_ready is high; returns just after that edge.
    task automatic send_byte(input logic [7:0] d);
        logic accepted;
        accepted = 1'b0;
        tx_data  = d;
        if (sel) tx_valid2 = 1'b1;
        else     tx_valid1 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (ready_sel === 1'b1) begin
                @(posedge CLK);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
        vectors++;
        if (accepted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL accept_%h: got %b expected 1", d, accepted);
        end
    endtask

    // Record n negedge samples of the selected instance, index 0 being the
    // first sample after the start bit falls.
    task automatic record_frame(input int n);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (txd_sel === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_bit: got %b expected 1", found);
            for (int i = 0; i < 256; i++) begin
                rec_txd[i]  = 1'bx;
                rec_rdy[i]  = 1'bx;
                rec_busy[i] = 1'bx;
            end
        end else begin
            rec_txd[0]  = txd_sel;
            rec_rdy[0]  = ready_sel;
            rec_busy[0] = busy_sel;
            for (int i = 1; i < n; i++) begin
                @(negedge CLK);
                rec_txd[i]  = txd_sel;
                rec_rdy[i]  = ready_sel;
                rec_busy[i] = busy_sel;
            end
        end
    endtask

    // Power-on reset: line idle, ready high, busy low on both instances.
    task automatic test_reset();
        #2;
        HRESET = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++; if (txd1 !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset_txd1: got %b expected 1", txd1); end
        vectors++; if (tx_ready1 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready1: got %b expected 1", tx_ready1); end
        vectors++; if (tx_busy1 !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_busy1: got %b expected 0", tx_busy1); end
        vectors++; if (txd2 !== 1'b1)      begin miscompares++; $display("[TB] FAIL reset_txd2: got %b expected 1", txd2); end
        vectors++; if (tx_ready2 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready2: got %b expected 1", tx_ready2); end
        vectors++; if (tx_busy2 !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_busy2: got %b expected 0", tx_busy2); end
        HRESET  = 1'b1;
        div_run = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
    endtask

    // 0x55 on dut1: alternating line, ready back after the full frame, and
    // ready/busy complementary throughout.
    task automatic test_frame_55();
        logic exp_bit, got_bit, compl_bad;
        int   idx;
        sel = 1'b0;
        fork
            send_byte(8'h55);
            record_frame((13 + NPAR) * BIT_CYC);
        join
        for (int k = 0; k < 12 + NPAR; k++) begin
            exp_bit = frame_bit(8'h55, k, 1'b0);
            got_bit = rec_txd[k * BIT_CYC + 4];
            vectors++;
            if (got_bit !== exp_bit) begin
                miscompares++;
                $display("[TB] FAIL frame55_bit%0d: got %b expected %b", k, got_bit, exp_bit);
            end
        end
        idx = (10 + NPAR) * BIT_CYC;
        vectors++; if (rec_rdy[idx-1] !== 1'b0) begin miscompares++; $display("[TB] FAIL frame55_ready_early: got %b expected 0", rec_rdy[idx-1]); end
        vectors++; if (rec_rdy[idx] !== 1'b1)   begin miscompares++; $display("[TB] FAIL frame55_ready_rise: got %b expected 1", rec_rdy[idx]); end
        compl_bad = 1'b0;
        for (int i = 0; i < (13 + NPAR) * BIT_CYC; i++) begin
            if (rec_rdy[i] === rec_busy[i]) compl_bad = 1'b1;
        end
        vectors++;
        if (compl_bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_busy_complement: got %b expected 0", compl_bad);
        end
        repeat (20) @(posedge CLK);
        #1;
    endtask

`ifdef UART_TX_PARITY_EN
    // Even sense on 0x07 (three ones) and odd sense on 0x55 (four ones) both
    // give a parity bit of 1.
    task automatic test_parity();
        int idx;
        sel = 1'b0;
        fork
            send_byte(8'h07);
            record_frame(12 * BIT_CYC);
        join
        vectors++; if (rec_txd[9*BIT_CYC+4] !== 1'b1)  begin miscompares++; $display("[TB] FAIL parity_even_07: got %b expected 1", rec_txd[9*BIT_CYC+4]); end
        vectors++; if (rec_txd[8*BIT_CYC+4] !== 1'b0)  begin miscompares++; $display("[TB] FAIL parity_even_07_bit7: got %b expected 0", rec_txd[8*BIT_CYC+4]); end
        vectors++; if (rec_txd[10*BIT_CYC+4] !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_even_07_stop: got %b expected 1", rec_txd[10*BIT_CYC+4]); end
        repeat (20) @(posedge CLK);
        #1;
        sel = 1'b1;
        fork
            send_byte(8'h55);
            record_frame(14 * BIT_CYC);
        join
        vectors++; if (rec_txd[9*BIT_CYC+4] !== 1'b1)  begin miscompares++; $display("[TB] FAIL parity_odd_55: got %b expected 1", rec_txd[9*BIT_CYC+4]); end
        vectors++; if (rec_txd[11*BIT_CYC+4] !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_odd_55_stop2: got %b expected 1", rec_txd[11*BIT_CYC+4]); end
        idx = 12 * BIT_CYC;
        vectors++; if (rec_rdy[idx-1] !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_odd_ready_early: got %b expected 0", rec_rdy[idx-1]); end
        vectors++; if (rec_rdy[idx] !== 1'b1)   begin miscompares++; $display("[TB] FAIL parity_odd_ready_rise: got %b expected 1", rec_rdy[idx]); end
        repeat (20) @(posedge CLK);
        #1;
    endtask
`endif

    // dut2 (two stop bits): 0xFF then 0x00 with tx_valid held. The second
    // byte is taken on the edge after ready rises and its start bit goes out
    // on the very next tick, one bit slot after the second stop bit ends.
    task automatic test_back_to_back();
        logic exp_bit, got_bit;
        int   k2, idx;
        sel = 1'b1;
        fork
            begin
                send_byte(8'hFF);
                send_byte(8'h00);
            end
            record_frame((24 + 2 * NPAR) * BIT_CYC);
        join
        for (int k = 0; k < 12 + NPAR; k++) begin
            exp_bit = frame_bit(8'hFF, k, 1'b1);
            got_bit = rec_txd[k * BIT_CYC + 4];
            vectors++;
            if (got_bit !== exp_bit) begin
                miscompares++;
                $display("[TB] FAIL b2b_ff_bit%0d: got %b expected %b", k, got_bit, exp_bit);
            end
        end
        k2 = 12 + NPAR;
        for (int j = 0; j < 11 + NPAR; j++) begin
            exp_bit = frame_bit(8'h00, j, 1'b1);
            got_bit = rec_txd[(k2 + j) * BIT_CYC + 4];
            vectors++;
            if (got_bit !== exp_bit) begin
                miscompares++;
                $display("[TB] FAIL b2b_00_bit%0d: got %b expected %b", j, got_bit, exp_bit);
            end
        end
        idx = (11 + NPAR) * BIT_CYC;
        vectors++; if (rec_rdy[idx-1] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ready_early: got %b expected 0", rec_rdy[idx-1]); end
        vectors++; if (rec_rdy[idx] !== 1'b1)   begin miscompares++; $display("[TB] FAIL b2b_ready_rise: got %b expected 1", rec_rdy[idx]); end
        vectors++; if (rec_rdy[idx+1] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_second_accept: got %b expected 0", rec_rdy[idx+1]); end
        repeat (20) @(posedge CLK);
        #1;
        sel = 1'b0;
    endtask

    // A one-cycle 0xAA offer in the middle of a 0x3C frame must be dropped:
    // the frame stays intact and the line idles afterwards.
    task automatic test_ignore_busy();
        logic exp_bit, got_bit;
        int   last;
        sel = 1'b0;
        fork
            send_byte(8'h3C);
            record_frame((14 + NPAR) * BIT_CYC);
            begin
                repeat (30) @(negedge CLK);
                @(posedge CLK);
                #1;
                tx_data   = 8'hAA;
                tx_valid1 = 1'b1;
                @(posedge CLK);
                #1;
                tx_valid1 = 1'b0;
            end
        join
        for (int k = 0; k < 14 + NPAR; k++) begin
            exp_bit = frame_bit(8'h3C, k, 1'b0);
            got_bit = rec_txd[k * BIT_CYC + 4];
            vectors++;
            if (got_bit !== exp_bit) begin
                miscompares++;
                $display("[TB] FAIL ignore_3c_bit%0d: got %b expected %b", k, got_bit, exp_bit);
            end
        end
        last = (14 + NPAR) * BIT_CYC - 1;
        vectors++; if (rec_rdy[last] !== 1'b1)  begin miscompares++; $display("[TB] FAIL ignore_ready_end: got %b expected 1", rec_rdy[last]); end
        vectors++; if (rec_busy[last] !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_busy_end: got %b expected 0", rec_busy[last]); end
        repeat (20) @(posedge CLK);
        #1;
    endtask

    // Freeze div_clk for 40 cycles inside data bit 2 of 0x96: the line and
    // busy hold, then the rest of the frame follows 40 cycles late.
    task automatic test_stall();
        logic exp_bit, got_bit, found;
        int   idx;
        sel = 1'b0;
        fork
            send_byte(8'h96);
            record_frame((12 + NPAR) * BIT_CYC + 40);
            begin
                found = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge CLK);
                    if (txd1 === 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    repeat (26) @(negedge CLK);
                    div_run = 1'b0;
                    repeat (40) @(negedge CLK);
                    div_run = 1'b1;
                end
            end
        join
        for (int k = 0; k < 11 + NPAR; k++) begin
            exp_bit = frame_bit(8'h96, k, 1'b0);
            got_bit = (k < 4) ? rec_txd[k * BIT_CYC + 4] : rec_txd[k * BIT_CYC + 44];
            vectors++;
            if (got_bit !== exp_bit) begin
                miscompares++;
                $display("[TB] FAIL stall_bit%0d: got %b expected %b", k, got_bit, exp_bit);
            end
        end
        vectors++; if (rec_txd[60] !== 1'b1)  begin miscompares++; $display("[TB] FAIL stall_txd_frozen: got %b expected 1", rec_txd[60]); end
        vectors++; if (rec_busy[50] !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy: got %b expected 1", rec_busy[50]); end
        idx = (10 + NPAR) * BIT_CYC + 40;
        vectors++; if (rec_rdy[idx-1] !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_ready_early: got %b expected 0", rec_rdy[idx-1]); end
        vectors++; if (rec_rdy[idx] !== 1'b1)   begin miscompares++; $display("[TB] FAIL stall_ready_rise: got %b expected 1", rec_rdy[idx]); end
        repeat (20) @(posedge CLK);
        #1;
    endtask

    // Reset asserted during a low data bit of 0xA0: outputs return to idle
    // values within the cycle and the frame does not resume after release.
    task automatic test_reset_mid_frame();
        logic found, went_low;
        sel = 1'b0;
        fork
            send_byte(8'hA0);
            begin
                found = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge CLK);
                    if (txd1 === 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                end
                vectors++;
                if (found !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_start: got %b expected 1", found);
                end
                repeat (20) @(negedge CLK);
                vectors++; if (txd1 !== 1'b0)    begin miscompares++; $display("[TB] FAIL midreset_pre_txd: got %b expected 0", txd1); end
                vectors++; if (tx_busy1 !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_pre_busy: got %b expected 1", tx_busy1); end
                HRESET = 1'b0;
                #1;
                vectors++; if (txd1 !== 1'b1)      begin miscompares++; $display("[TB] FAIL midreset_txd: got %b expected 1", txd1); end
                vectors++; if (tx_ready1 !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_ready: got %b expected 1", tx_ready1); end
                vectors++; if (tx_busy1 !== 1'b0)  begin miscompares++; $display("[TB] FAIL midreset_busy: got %b expected 0", tx_busy1); end
                @(negedge CLK);
                HRESET   = 1'b1;
                went_low = 1'b0;
                for (int i = 0; i < 3 * BIT_CYC; i++) begin
                    @(negedge CLK);
                    if (txd1 !== 1'b1) went_low = 1'b1;
                end
                vectors++; if (went_low !== 1'b0)  begin miscompares++; $display("[TB] FAIL midreset_no_resume: got %b expected 0", went_low); end
                vectors++; if (tx_ready1 !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_idle_ready: got %b expected 1", tx_ready1); end
                vectors++; if (tx_busy1 !== 1'b0)  begin miscompares++; $display("[TB] FAIL midreset_idle_busy: got %b expected 0", tx_busy1); end
            end
        join
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_frame_55();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_ignore_busy();
        test_stall();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
